// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode operands/control, hazard controls, forwarding
// sources and the execute-side outputs of the ID/EX stage.
interface id_ex_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic             IdValid;
  logic [WIDTH-1:0] IdRD1;
  logic [WIDTH-1:0] IdRD2;
  logic [WIDTH-1:0] IdImm;
  logic [RADDR-1:0] IdRs;
  logic [RADDR-1:0] IdRt;
  logic [RADDR-1:0] IdRd;
  logic             IdALUSrc;
  logic             IdRegDst;
  logic [3:0]       IdALUControl;
  logic             IdRegWrite;
  logic             IdMemRead;
  logic             IdMemWrite;
  logic             IdMemtoReg;
  logic             Stall;
  logic             Flush;
  logic             ExMemRegWrite;
  logic [RADDR-1:0] ExMemRd;
  logic [WIDTH-1:0] ExMemResult;
  logic             MemWbRegWrite;
  logic [RADDR-1:0] MemWbRd;
  logic [WIDTH-1:0] MemWbData;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             ExValid;
  logic [RADDR-1:0] WriteReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic [WIDTH-1:0] StoreData;
  logic             LoadUseStall;

  modport master (
    output IdValid, IdRD1, IdRD2, IdImm, IdRs, IdRt, IdRd, IdALUSrc, IdRegDst,
           IdALUControl, IdRegWrite, IdMemRead, IdMemWrite, IdMemtoReg,
           Stall, Flush, ExMemRegWrite, ExMemRd, ExMemResult,
           MemWbRegWrite, MemWbRd, MemWbData,
    input  A, B, ALUControl, ExValid, WriteReg, RegWrite, MemRead, MemWrite,
           MemtoReg, StoreData, LoadUseStall
  );

  modport slave (
    input  IdValid, IdRD1, IdRD2, IdImm, IdRs, IdRt, IdRd, IdALUSrc, IdRegDst,
           IdALUControl, IdRegWrite, IdMemRead, IdMemWrite, IdMemtoReg,
           Stall, Flush, ExMemRegWrite, ExMemRd, ExMemResult,
           MemWbRegWrite, MemWbRd, MemWbData,
    output A, B, ALUControl, ExValid, WriteReg, RegWrite, MemRead, MemWrite,
           MemtoReg, StoreData, LoadUseStall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection feeding the ALU.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] wreg;
    logic             alu_src;
    logic [3:0]       alu_ctl;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d;
  logic     load_use;

  // A load in EX cannot forward its data yet; hold decode for one cycle.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.wreg != '0) && bus.IdValid &&
                    ((ex_q.wreg == bus.IdRs) || (ex_q.wreg == bus.IdRt));

  always_comb begin
    ex_d = ex_q;
    if (bus.Flush) begin
      ex_d = '0;
    end else if (bus.Stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = bus.IdValid;
      ex_d.rd1        = bus.IdRD1;
      ex_d.rd2        = bus.IdRD2;
      ex_d.imm        = bus.IdImm;
      ex_d.rs         = bus.IdRs;
      ex_d.rt         = bus.IdRt;
      ex_d.wreg       = bus.IdRegDst ? bus.IdRd : bus.IdRt;
      ex_d.alu_src    = bus.IdALUSrc;
      ex_d.alu_ctl    = bus.IdALUControl;
      ex_d.reg_write  = bus.IdRegWrite;
      ex_d.mem_read   = bus.IdMemRead;
      ex_d.mem_write  = bus.IdMemWrite;
      ex_d.mem_to_reg = bus.IdMemtoReg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Operand 0 is rs, operand 1 is rt; EX/MEM has priority and r0 never forwards.
  logic [RADDR-1:0] src_reg [2];
  logic [WIDTH-1:0] reg_val [2];
  logic [WIDTH-1:0] fwd_val [2];

  assign src_reg[0] = ex_q.rs;
  assign src_reg[1] = ex_q.rt;
  assign reg_val[0] = ex_q.rd1;
  assign reg_val[1] = ex_q.rd2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_exmem, hit_memwb;
      assign hit_exmem = bus.ExMemRegWrite && (bus.ExMemRd != '0) && (bus.ExMemRd == src_reg[gi]);
      assign hit_memwb = bus.MemWbRegWrite && (bus.MemWbRd != '0) && (bus.MemWbRd == src_reg[gi]);
      assign fwd_val[gi] = hit_exmem ? bus.ExMemResult :
                           hit_memwb ? bus.MemWbData   : reg_val[gi];
    end
  endgenerate

  assign bus.A            = fwd_val[0];
  assign bus.StoreData    = fwd_val[1];
  assign bus.B            = ex_q.alu_src ? ex_q.imm : fwd_val[1];
  assign bus.ALUControl   = ex_q.alu_ctl;
  assign bus.ExValid      = ex_q.valid;
  assign bus.WriteReg     = ex_q.wreg;
  assign bus.RegWrite     = ex_q.reg_write  && ex_q.valid;
  assign bus.MemRead      = ex_q.mem_read   && ex_q.valid;
  assign bus.MemWrite     = ex_q.mem_write  && ex_q.valid;
  assign bus.MemtoReg     = ex_q.mem_to_reg && ex_q.valid;
  assign bus.LoadUseStall = load_use;

endmodule
